// File: rtl/ir_pkg.sv
// rtl/ir_pkg.sv - shared IrDA serial defaults, state encoding and bit-timing helper
package ir_pkg;

  // Board clock and default line rate shared by the receiver, LED rotator and transmitter
  localparam int unsigned CLK_HZ_DEFAULT = 12_000_000;
  localparam int unsigned BAUD_DEFAULT   = 9_600;

  // Receiver frame states; IDLE is all-zero so a cleared register is idle
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // Whole clock cycles per serial bit (integer division, remainder dropped)
  function automatic int unsigned cycles_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/rx_sync.sv
// rtl/rx_sync.sv - two-flop synchronizer for the raw IrDA line plus falling-edge detect
module rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rxd,
  output logic rxd_s,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // Shift the raw line through two flops, then keep one more copy for edge detection
  always_comb begin
    meta_d = rxd;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // All stages reset to the idle-high line level so reset never looks like a start edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rxd_s = sync_q;
  assign fall  = prev_q & ~sync_q;

endmodule

// File: rtl/ir_uart_rx.sv
// rtl/ir_uart_rx.sv - 8N1 serial receiver for the IrDA transceiver line
module ir_uart_rx
  import ir_pkg::*;
#(
  parameter int unsigned CLK_HZ = CLK_HZ_DEFAULT,
  parameter int unsigned BAUD   = BAUD_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CPB   = cycles_per_bit(CLK_HZ, BAUD);
  localparam int          CNT_W = (CPB > 1) ? $clog2(CPB) : 1;

  // Start bit is checked half a bit in; every later sample is one full bit apart
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CPB - 1);

  logic rxd_s;
  logic fall;

  rx_sync u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .rxd   (rxd),
    .rxd_s (rxd_s),
    .fall  (fall)
  );

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [2:0]       idx_q,   idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       data_q,  data_d;
  logic             valid_q, valid_d;
  logic             ferr_q,  ferr_d;

  // Frame sequencing: counter only ever runs up to the current sample point, then clears
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (fall) begin
          state_d = RX_START;
        end
      end

      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          // A line already back high at mid start bit was a glitch, not a frame
          state_d = rxd_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shreg_d[idx_q] = rxd_s;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = RX_STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rxd_s) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = RX_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // State, timing and output registers; reset aborts any frame in flight without a strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != RX_IDLE);

endmodule

// File: tb/tb_ir_uart_rx.sv
// tb/tb_ir_uart_rx.sv - scoreboard bench for the IrDA serial receiver
module tb_ir_uart_rx;

  localparam int CLK_HZ = 12_000_000;
  localparam int BAUD   = 96_000;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int HALF   = CPB / 2;
  localparam int LAT    = 2 + HALF + 9 * CPB + 1;
  localparam int GLITCH = 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  ir_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_err;
    logic [7:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   cyc = 0;
  int   valid_cnt = 0;
  int   ferr_cnt = 0;
  int   busy_cycles = 0;
  int   last_strobe_cyc = 0;

  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (busy === 1'b1) busy_cycles++;
    if (valid === 1'b1 || frame_err === 1'b1) begin
      tests_run++;
      last_strobe_cyc = cyc;
      if (valid === 1'b1 && frame_err === 1'b1) begin
        tests_failed++;
        $display("FAIL strobe_overlap: valid=%b frame_err=%b, required only one high", valid, frame_err);
      end else if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_strobe: valid=%b frame_err=%b data=%h, required no strobe", valid, frame_err, data);
      end else begin
        e = exp_q.pop_front();
        if (frame_err !== e.is_err || (!e.is_err && data !== e.val)) begin
          tests_failed++;
          $display("FAIL scoreboard: got valid=%b frame_err=%b data=%h, required frame_err=%b data=%h",
                   valid, frame_err, data, e.is_err, e.val);
        end
      end
      if (valid === 1'b1) valid_cnt++;
      if (frame_err === 1'b1) ferr_cnt++;
    end
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    repeat (CPB) tick();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (3) tick();
    tests_run++;
    if (data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h, required 00", data); end
    tests_run++;
    if (valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b, required 0", valid); end
    tests_run++;
    if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_err: got %b, required 0", frame_err); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b, required 0", busy); end
    rst_n = 1'b1;
    repeat (5) tick();
  endtask

  task automatic test_single_byte();
    int v0, f0, c0;
    v0 = valid_cnt; f0 = ferr_cnt; busy_cycles = 0;
    exp_q.push_back(exp_t'{1'b0, 8'h55});
    c0 = cyc;
    send_frame(8'h55, 1'b1);
    repeat (CPB) tick();
    tests_run++;
    if (valid_cnt - v0 != 1) begin tests_failed++; $display("FAIL single_valid_count: got %0d, required 1", valid_cnt - v0); end
    tests_run++;
    if (ferr_cnt != f0) begin tests_failed++; $display("FAIL single_no_ferr: got %0d, required 0", ferr_cnt - f0); end
    tests_run++;
    if (data !== 8'h55) begin tests_failed++; $display("FAIL single_data: got %h, required 55", data); end
    tests_run++;
    if (last_strobe_cyc - c0 != LAT) begin tests_failed++; $display("FAIL single_latency: got %0d, required %0d", last_strobe_cyc - c0, LAT); end
    tests_run++;
    if (busy_cycles != HALF + 9 * CPB) begin tests_failed++; $display("FAIL single_busy_time: got %0d, required %0d", busy_cycles, HALF + 9 * CPB); end
  endtask

  task automatic test_glitch();
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt; busy_cycles = 0;
    rxd = 1'b0;
    repeat (GLITCH) tick();
    rxd = 1'b1;
    repeat (HALF + 4 - GLITCH) tick();
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL glitch_busy_low: got %b, required 0", busy); end
    tests_run++;
    if (busy_cycles != HALF) begin tests_failed++; $display("FAIL glitch_busy_time: got %0d, required %0d", busy_cycles, HALF); end
    repeat (CPB) tick();
    tests_run++;
    if (valid_cnt != v0 || ferr_cnt != f0) begin
      tests_failed++;
      $display("FAIL glitch_no_strobe: got valid %0d ferr %0d, required 0 0", valid_cnt - v0, ferr_cnt - f0);
    end
  endtask

  task automatic test_frame_err();
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    exp_q.push_back(exp_t'{1'b1, 8'h00});
    send_frame(8'hA3, 1'b0);
    rxd = 1'b1;
    repeat (CPB) tick();
    tests_run++;
    if (ferr_cnt - f0 != 1) begin tests_failed++; $display("FAIL ferr_count: got %0d, required 1", ferr_cnt - f0); end
    tests_run++;
    if (valid_cnt != v0) begin tests_failed++; $display("FAIL ferr_no_valid: got %0d, required 0", valid_cnt - v0); end
    tests_run++;
    if (data !== 8'h55) begin tests_failed++; $display("FAIL ferr_data_kept: got %h, required 55", data); end
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = valid_cnt;
    exp_q.push_back(exp_t'{1'b0, 8'h00});
    exp_q.push_back(exp_t'{1'b0, 8'hFF});
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (CPB) tick();
    tests_run++;
    if (valid_cnt - v0 != 2) begin tests_failed++; $display("FAIL b2b_valid_count: got %0d, required 2", valid_cnt - v0); end
    tests_run++;
    if (data !== 8'hFF) begin tests_failed++; $display("FAIL b2b_data: got %h, required ff", data); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    int v0, f0;
    b = 8'h3C;
    v0 = valid_cnt; f0 = ferr_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    rxd = b[4];
    repeat (HALF) tick();
    rst_n = 1'b0;
    repeat (3) tick();
    tests_run++;
    if (data !== 8'h00) begin tests_failed++; $display("FAIL abort_data: got %h, required 00", data); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL abort_busy: got %b, required 0", busy); end
    rxd   = 1'b1;
    rst_n = 1'b1;
    repeat (2 * CPB) tick();
    tests_run++;
    if (valid_cnt != v0 || ferr_cnt != f0) begin
      tests_failed++;
      $display("FAIL abort_no_strobe: got valid %0d ferr %0d, required 0 0", valid_cnt - v0, ferr_cnt - f0);
    end
    exp_q.push_back(exp_t'{1'b0, 8'h81});
    send_frame(8'h81, 1'b1);
    repeat (CPB) tick();
    tests_run++;
    if (data !== 8'h81) begin tests_failed++; $display("FAIL after_abort_data: got %h, required 81", data); end
    tests_run++;
    if (valid_cnt - v0 != 1) begin tests_failed++; $display("FAIL after_abort_valid: got %0d, required 1", valid_cnt - v0); end
  endtask

  task automatic test_break();
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    exp_q.push_back(exp_t'{1'b1, 8'h00});
    rxd = 1'b0;
    repeat (20 * CPB) tick();
    rxd = 1'b1;
    repeat (2 * CPB) tick();
    tests_run++;
    if (ferr_cnt - f0 != 1) begin tests_failed++; $display("FAIL break_ferr_count: got %0d, required 1", ferr_cnt - f0); end
    tests_run++;
    if (valid_cnt != v0) begin tests_failed++; $display("FAIL break_no_valid: got %0d, required 0", valid_cnt - v0); end
    tests_run++;
    if (data !== 8'h81) begin tests_failed++; $display("FAIL break_data_kept: got %h, required 81", data); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL break_busy: got %b, required 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid_frame();
    test_break();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drained: got %0d pending, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
